// File: rtl/psg_voice_pkg.sv
// Shared types and defaults for the PSG voice allocator.
package psg_voice_pkg;
  localparam int PSG_NVOICE = 5;
  localparam int PSG_NOTEW  = 16;
  localparam int PSG_KEYW   = 7;
  localparam int PSG_AGEW   = 3;

  typedef enum logic [1:0] {IDLE, SEARCH, ISSUE} state_t;
  typedef logic [PSG_KEYW-1:0] key_t;
  typedef logic [PSG_AGEW-1:0] age_t;
endpackage

// File: rtl/psg_voice_pick.sv
// Combinational voice priority finder: key match, free, releasing, then oldest.
// Oldest-voice stealing is present only when PSG_VOICE_STEAL_EN is defined.
module psg_voice_pick
  import psg_voice_pkg::*;
#(
  parameter int NVOICE = PSG_NVOICE
`ifdef PSG_VOICE_STEAL_EN
  ,
  parameter int AGEW   = PSG_AGEW
`endif
) (
  input  logic                 i_on,
  input  logic [NVOICE-1:0]    i_gate,
  input  logic [NVOICE-1:0]    i_busy,
  input  logic [NVOICE-1:0]    i_match,
`ifdef PSG_VOICE_STEAL_EN
  input  logic [NVOICE*AGEW-1:0] i_age,
`endif
  output logic [NVOICE-1:0]    o_pick,
  output logic                 o_hit
);

  logic [NVOICE-1:0] w_match, w_free, w_rel, w_cand, w_oldest;
  logic              w_found;

  assign w_match = i_gate & i_match;
  assign w_free  = ~i_gate & ~i_busy;
  assign w_rel   = ~i_gate;

`ifdef PSG_VOICE_STEAL_EN
  logic [AGEW-1:0] w_best_age;
  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    w_oldest   = '0;
    w_oldest[0] = 1'b1;
    w_best_age = i_age[0 +: AGEW];
    for (int unsigned i = 1; i < NVOICE; i++) begin
      if (i_age[i*AGEW +: AGEW] > w_best_age) begin
        w_best_age = i_age[i*AGEW +: AGEW];
        w_oldest   = '0;
        w_oldest[i] = 1'b1;
      end
    end
  end
`else
  assign w_oldest = '0;
`endif

  always_comb begin
    w_cand = '0;
    if (|w_match)      w_cand = w_match;
    else if (i_on) begin
      if (|w_free)     w_cand = w_free;
      else if (|w_rel) w_cand = w_rel;
      else             w_cand = w_oldest;
    end
  end

  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NVOICE; i++) begin
      if (w_cand[i] && !w_found) begin
        o_pick[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  assign o_hit = |w_cand;

endmodule

// File: rtl/psg_voice_alloc.sv
// Note-event voice allocator: IDLE -> SEARCH -> ISSUE per request, drives per-voice gate/freq/load.
// Define PSG_VOICE_STEAL_EN to steal the oldest voice when every voice is gated.
module psg_voice_alloc
  import psg_voice_pkg::*;
#(
  parameter int NVOICE = PSG_NVOICE,
  parameter int NOTEW  = PSG_NOTEW,
  parameter int KEYW   = PSG_KEYW,
  parameter int AGEW   = PSG_AGEW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_on,
  input  logic [KEYW-1:0]         req_key,
  input  logic [NOTEW-1:0]        req_freq,
  input  logic                    all_off,
  input  logic [NVOICE-1:0]       v_busy,
  output logic [NVOICE-1:0]       v_gate,
  output logic [NVOICE*NOTEW-1:0] v_freq,
  output logic [NVOICE-1:0]       v_load,
  output logic [NVOICE-1:0]       v_active,
  output logic                    drop
);

  state_t                   r_state, w_next;
  logic                     r_rdy_en;
  logic                     r_on;
  logic [KEYW-1:0]          r_key;
  logic [NOTEW-1:0]         r_nfreq;
  logic [NVOICE*KEYW-1:0]   r_keys;
  logic [NVOICE*AGEW-1:0]   r_age;
  logic [NVOICE*NOTEW-1:0]  r_vfreq;
  logic [NVOICE-1:0]        r_gate, r_load, r_active, r_pick;
  logic                     r_hit, r_drop;
  logic                     w_xfer, w_in_search, w_in_issue;
  logic [NVOICE-1:0]        w_match, w_pick;
  logic                     w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_next = SEARCH;
      SEARCH:  w_next = ISSUE;
      ISSUE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (all_off) w_next = IDLE;
  end

  always_comb begin
    req_ready   = r_rdy_en && (r_state == IDLE) && !all_off;
    w_xfer      = req_valid && req_ready;
    w_in_search = (r_state == SEARCH);
    w_in_issue  = (r_state == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on    <= 1'b0;
      r_key   <= '0;
      r_nfreq <= '0;
      r_pick  <= '0;
      r_hit   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_on    <= req_on;
        r_key   <= req_key;
        r_nfreq <= req_freq;
      end
      if (w_in_search) begin
        r_pick <= w_pick;
        r_hit  <= w_hit;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NVOICE; i++)
      w_match[i] = (r_keys[i*KEYW +: KEYW] == r_key);
  end

  psg_voice_pick #(
    .NVOICE (NVOICE)
`ifdef PSG_VOICE_STEAL_EN
    ,
    .AGEW   (AGEW)
`endif
  ) u_pick (
    .i_on    (r_on),
    .i_gate  (r_gate),
    .i_busy  (v_busy),
    .i_match (w_match),
`ifdef PSG_VOICE_STEAL_EN
    .i_age   (r_age),
`endif
    .o_pick  (w_pick),
    .o_hit   (w_hit)
  );

  // all_off wins over an ISSUE in the same cycle, so an in-flight request is silently aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate  <= '0;
      r_keys  <= '0;
      r_age   <= '0;
      r_vfreq <= '0;
      r_load  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_load <= '0;
      r_drop <= 1'b0;
      if (all_off) begin
        r_gate <= '0;
        r_age  <= '0;
      end else if (w_in_issue) begin
        if (!r_hit) begin
          r_drop <= 1'b1;
        end else if (r_on) begin
          r_gate <= r_gate | r_pick;
          r_load <= r_pick;
          for (int unsigned i = 0; i < NVOICE; i++) begin
            if (r_pick[i]) begin
              r_keys[i*KEYW +: KEYW]    <= r_key;
              r_vfreq[i*NOTEW +: NOTEW] <= r_nfreq;
              r_age[i*AGEW +: AGEW]     <= '0;
            end else if (r_gate[i] && (r_age[i*AGEW +: AGEW] != '1)) begin
              r_age[i*AGEW +: AGEW] <= r_age[i*AGEW +: AGEW] + 1'b1;
            end
          end
        end else begin
          r_gate <= r_gate & ~r_pick;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_active <= '0;
    else        r_active <= r_gate | v_busy;
  end

  assign v_gate   = r_gate;
  assign v_freq   = r_vfreq;
  assign v_load   = r_load;
  assign v_active = r_active;
  assign drop     = r_drop;

endmodule
